// File: rtl/mem_ctrl_arb.sv
`default_nettype none
// ============================================================================
// mem_ctrl_arb : byte-serial RAM/IO controller, round-robin fetch/LSB arbiter.
// Optional one-entry fetch buffer: define MEM_CTRL_FETCH_BUF_EN.   Rev 1.0
// ============================================================================
module mem_ctrl_arb #(
   parameter int ADDR_W      = 32,
   parameter int FETCH_BYTES = 4,
   parameter int IO_SEL_HI   = 17,
   parameter int IO_SEL_LO   = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic [31:0]       fetch_data,
   input  logic              flush,
   input  logic              lsb_req,
   input  logic              lsb_we,
   input  logic [1:0]        lsb_size,
   input  logic              lsb_signed,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [31:0]       lsb_wdata,
   output logic              lsb_ready,
   output logic [31:0]       lsb_rdata,
   output logic              busy
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_READ = 3'd1, S_WRITE = 3'd2, S_IO_WAIT = 3'd3, S_DONE = 3'd4
   } state_t;

   localparam logic [2:0] c_fetch_n = 3'(FETCH_BYTES);

   function automatic logic is_io(input logic [ADDR_W-1:0] a);
      return &a[IO_SEL_HI:IO_SEL_LO];
   endfunction

   function automatic logic [2:0] size_bytes(input logic [1:0] s);
      case (s)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d, nbytes_q, nbytes_d;
   logic [ADDR_W-1:0] base_q, base_d, mem_a_q, mem_a_d;
   logic              is_fetch_q, is_fetch_d, signed_q, signed_d, rr_lsb_q, rr_lsb_d;
   logic [31:0]       wdata_q, wdata_d, buf_q, buf_d;
   logic [7:0]        mem_dout_q, mem_dout_d;
   logic              mem_wr_q, mem_wr_d, fetch_ready_q, fetch_ready_d, lsb_ready_q, lsb_ready_d;
   logic [31:0]       fetch_data_q, fetch_data_d, lsb_rdata_q, lsb_rdata_d;

   logic [2:0]        w_cnt_inc;
   logic [1:0]        w_idx;
   logic [ADDR_W-1:0] w_next_addr;
   logic              w_fetch_ok, w_lsb_ok, w_pick_lsb;
   logic [31:0]       w_buf_upd, w_load_ext;

   assign w_cnt_inc   = cnt_q + 3'd1;
   assign w_idx       = cnt_q[1:0] - 2'd1;
   assign w_next_addr = base_q + ADDR_W'(w_cnt_inc);
   // flush only masks speculative reads; stores stay grantable
   assign w_fetch_ok  = fetch_req & ~flush;
   assign w_lsb_ok    = lsb_req & (lsb_we | ~flush);
   assign w_pick_lsb  = w_lsb_ok & (rr_lsb_q | ~w_fetch_ok);

`ifdef MEM_CTRL_FETCH_BUF_EN
   logic              fb_valid_q, fb_valid_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [31:0]       fb_data_q, fb_data_d;
   logic              w_fb_hit, w_fb_overlap;
   logic [ADDR_W-1:0] w_st_minus_fb, w_fb_minus_st;

   // modular range overlap between the store bytes and the buffered fetch bytes
   assign w_st_minus_fb = lsb_addr - fb_addr_q;
   assign w_fb_minus_st = fb_addr_q - lsb_addr;
   assign w_fb_overlap  = (w_st_minus_fb < ADDR_W'(FETCH_BYTES)) ||
                          (w_fb_minus_st < ADDR_W'(size_bytes(lsb_size)));
   assign w_fb_hit      = fb_valid_q && (fb_addr_q == fetch_addr);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         fb_valid_q <= 1'b0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
      end else if (rdy_in) begin
         fb_valid_q <= fb_valid_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
      end
   end
`endif

   always_comb begin
      w_buf_upd = buf_q;
      w_buf_upd[{w_idx, 3'b000} +: 8] = mem_din;
      case (nbytes_q)
         3'd1:    w_load_ext = {{24{signed_q & w_buf_upd[7]}},  w_buf_upd[7:0]};
         3'd2:    w_load_ext = {{16{signed_q & w_buf_upd[15]}}, w_buf_upd[15:0]};
         3'd3:    w_load_ext = {{8{signed_q & w_buf_upd[23]}},  w_buf_upd[23:0]};
         default: w_load_ext = w_buf_upd;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      nbytes_d      = nbytes_q;
      base_d        = base_q;
      is_fetch_d    = is_fetch_q;
      signed_d      = signed_q;
      wdata_d       = wdata_q;
      buf_d         = buf_q;
      rr_lsb_d      = rr_lsb_q;
      mem_a_d       = mem_a_q;
      mem_dout_d    = mem_dout_q;
      mem_wr_d      = 1'b0;
      fetch_ready_d = 1'b0;
      lsb_ready_d   = 1'b0;
      fetch_data_d  = fetch_data_q;
      lsb_rdata_d   = lsb_rdata_q;
`ifdef MEM_CTRL_FETCH_BUF_EN
      fb_valid_d    = fb_valid_q;
      fb_addr_d     = fb_addr_q;
      fb_data_d     = fb_data_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (w_fetch_ok | w_lsb_ok) begin
               if (w_fetch_ok & w_lsb_ok) rr_lsb_d = ~rr_lsb_q;
               cnt_d      = 3'd0;
               buf_d      = '0;
               is_fetch_d = ~w_pick_lsb;
               if (w_pick_lsb) begin
                  base_d   = lsb_addr;
                  mem_a_d  = lsb_addr;
                  nbytes_d = size_bytes(lsb_size);
                  signed_d = lsb_signed;
                  wdata_d  = lsb_wdata;
                  if (lsb_we) begin
                     mem_dout_d = lsb_wdata[7:0];
`ifdef MEM_CTRL_FETCH_BUF_EN
                     if (w_fb_overlap) fb_valid_d = 1'b0;
`endif
                     if (is_io(lsb_addr) && io_buffer_full) begin
                        state_d = S_IO_WAIT;
                     end else begin
                        state_d  = S_WRITE;
                        mem_wr_d = 1'b1;
                     end
                  end else begin
                     state_d = S_READ;
                  end
               end else begin
                  base_d   = fetch_addr;
                  mem_a_d  = fetch_addr;
                  nbytes_d = c_fetch_n;
                  signed_d = 1'b0;
                  state_d  = S_READ;
`ifdef MEM_CTRL_FETCH_BUF_EN
                  if (w_fb_hit) begin
                     mem_a_d       = mem_a_q;
                     state_d       = S_DONE;
                     fetch_ready_d = 1'b1;
                     fetch_data_d  = fb_data_q;
                  end
`endif
               end
            end
         end
         S_READ: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = w_cnt_inc;
               // mem_din trails the address by one cycle, so byte cnt-1 arrives now
               if (cnt_q != 3'd0) buf_d = w_buf_upd;
               if (w_cnt_inc < nbytes_q) mem_a_d = w_next_addr;
               if (cnt_q == nbytes_q) begin
                  state_d = S_DONE;
                  if (is_fetch_q) begin
                     fetch_ready_d = 1'b1;
                     fetch_data_d  = w_load_ext;
`ifdef MEM_CTRL_FETCH_BUF_EN
                     fb_valid_d = 1'b1;
                     fb_addr_d  = base_q;
                     fb_data_d  = w_load_ext;
`endif
                  end else begin
                     lsb_ready_d = 1'b1;
                     lsb_rdata_d = w_load_ext;
                  end
               end
            end
         end
         S_WRITE: begin
            cnt_d = w_cnt_inc;
            if (w_cnt_inc == nbytes_q) begin
               state_d     = S_DONE;
               lsb_ready_d = 1'b1;
            end else begin
               mem_a_d    = w_next_addr;
               mem_dout_d = wdata_q[{w_cnt_inc[1:0], 3'b000} +: 8];
               if (is_io(w_next_addr) && io_buffer_full) state_d = S_IO_WAIT;
               else                                      mem_wr_d = 1'b1;
            end
         end
         S_IO_WAIT: begin
            if (!io_buffer_full) begin
               state_d  = S_WRITE;
               mem_wr_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         nbytes_q      <= '0;
         base_q        <= '0;
         is_fetch_q    <= 1'b0;
         signed_q      <= 1'b0;
         wdata_q       <= '0;
         buf_q         <= '0;
         rr_lsb_q      <= 1'b1;
         mem_a_q       <= '0;
         mem_dout_q    <= '0;
         mem_wr_q      <= 1'b0;
         fetch_ready_q <= 1'b0;
         lsb_ready_q   <= 1'b0;
         fetch_data_q  <= '0;
         lsb_rdata_q   <= '0;
      end else if (rdy_in) begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         nbytes_q      <= nbytes_d;
         base_q        <= base_d;
         is_fetch_q    <= is_fetch_d;
         signed_q      <= signed_d;
         wdata_q       <= wdata_d;
         buf_q         <= buf_d;
         rr_lsb_q      <= rr_lsb_d;
         mem_a_q       <= mem_a_d;
         mem_dout_q    <= mem_dout_d;
         mem_wr_q      <= mem_wr_d;
         fetch_ready_q <= fetch_ready_d;
         lsb_ready_q   <= lsb_ready_d;
         fetch_data_q  <= fetch_data_d;
         lsb_rdata_q   <= lsb_rdata_d;
      end
   end

   // a stalled write cycle is retried once rdy_in returns, so suppress the strobe now
   assign mem_wr      = mem_wr_q & rdy_in;
   assign mem_a       = mem_a_q;
   assign mem_dout    = mem_dout_q;
   assign fetch_ready = fetch_ready_q;
   assign fetch_data  = fetch_data_q;
   assign lsb_ready   = lsb_ready_q;
   assign lsb_rdata   = lsb_rdata_q;
   assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_arb.sv
`default_nettype none
// tb_mem_ctrl_arb : directed + randomized bench for mem_ctrl_arb, with a
// byte-level memory model and a shadow image used to predict every result.
module tb_mem_ctrl_arb;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, io_buffer_full, flush;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        fetch_req, fetch_ready;
   logic [31:0] fetch_addr, fetch_data;
   logic        lsb_req, lsb_we, lsb_signed, lsb_ready;
   logic [1:0]  lsb_size;
   logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;
   bit mdl_ptr_lsb = 1'b1;
   logic [7:0] ram    [logic [31:0]];
   logic [7:0] shadow [logic [31:0]];

   always #5 clk_in = ~clk_in;

   mem_ctrl_arb dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .fetch_data(fetch_data), .flush(flush),
      .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size), .lsb_signed(lsb_signed),
      .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_ready(lsb_ready),
      .lsb_rdata(lsb_rdata), .busy(busy)
   );

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // RAM/IO bus: data for the address of cycle k appears in cycle k+1
   always @(posedge clk_in) begin
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : init_byte(mem_a);
      if (mem_wr) ram[mem_a] = mem_dout;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] sh_rd(input logic [31:0] a);
      return shadow.exists(a) ? shadow[a] : init_byte(a);
   endfunction

   function automatic int nb(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [31:0] a, input int n, input bit sg);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(sh_rd(a + 32'(i))) << (8 * i));
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_in);
      #1;
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] d);
      ram[a]    = d;
      shadow[a] = d;
   endtask

   task automatic do_read(input bit is_f, input logic [31:0] addr, input logic [1:0] size,
                          input bit sg, input string tag);
      int n;
      bit done;
      logic [31:0] exp;
      n    = is_f ? 4 : nb(size);
      exp  = mdl_load(addr, n, is_f ? 1'b0 : sg);
      done = 1'b0;
      next_cycle();
      if (is_f) begin
         fetch_addr = addr; fetch_req = 1'b1;
      end else begin
         lsb_addr = addr; lsb_size = size; lsb_signed = sg; lsb_we = 1'b0; lsb_req = 1'b1;
      end
      for (int c = 1; c <= 60; c++) begin
         next_cycle();
         #1;
         if (c <= n) begin
            chk({tag, "_addr"}, mem_a, addr + 32'(c - 1));
            chk({tag, "_nowr"}, mem_wr, 1'b0);
         end
         if (is_f ? fetch_ready : lsb_ready) begin
            chk({tag, "_lat"}, 32'(c), 32'(n + 2));
            chk({tag, "_data"}, is_f ? fetch_data : lsb_rdata, exp);
            fetch_req = 1'b0; lsb_req = 1'b0;
            done = 1'b1;
            break;
         end
      end
      chk({tag, "_done"}, done, 1'b1);
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                           input int st_start, input int st_len, input int io_len, input string tag);
      int n, k;
      bit done, prev_io;
      n = nb(size); k = 0; done = 1'b0;
      for (int i = 0; i < n; i++) shadow[addr + 32'(i)] = 8'(wd >> (8 * i));
      next_cycle();
      lsb_addr = addr; lsb_size = size; lsb_wdata = wd; lsb_signed = 1'b0;
      lsb_we = 1'b1; lsb_req = 1'b1; io_buffer_full = (io_len > 0);
      prev_io = io_buffer_full;
      for (int c = 1; c <= 80; c++) begin
         next_cycle();
         rdy_in         = !(st_len > 0 && c >= st_start && c < st_start + st_len);
         io_buffer_full = (c < io_len);
         #1;
         if (lsb_ready) begin
            chk({tag, "_lat"}, 32'(c), 32'(n + 1 + st_len + io_len));
            chk({tag, "_nwr"}, 32'(k), 32'(n));
            lsb_req = 1'b0; lsb_we = 1'b0;
            done = 1'b1;
            break;
         end
         if (mem_wr) begin
            chk({tag, "_waddr"}, mem_a, addr + 32'(k));
            chk({tag, "_wdata"}, 32'(mem_dout), 32'(8'(wd >> (8 * (k & 3)))));
            chk({tag, "_iogate"}, prev_io, 1'b0);
            k++;
         end else if (!rdy_in) begin
            chk({tag, "_hold"}, mem_a, addr + 32'(k));
         end
         prev_io = io_buffer_full;
      end
      chk({tag, "_done"}, done, 1'b1);
      rdy_in = 1'b1; io_buffer_full = 1'b0;
   endtask

   task automatic run_both(input logic [31:0] fa, input logic [31:0] la, input logic [1:0] ls,
                           input bit sg);
      bit exp_lsb_first, got_f, got_l, first_lsb;
      int lat1, nl;
      logic [31:0] fexp, lexp;
      nl   = nb(ls);
      fexp = mdl_load(fa, 4, 1'b0);
      lexp = mdl_load(la, nl, sg);
      exp_lsb_first = mdl_ptr_lsb;
      mdl_ptr_lsb   = ~mdl_ptr_lsb;
      got_f = 1'b0; got_l = 1'b0; first_lsb = 1'b0; lat1 = 0;
      next_cycle();
      fetch_addr = fa; fetch_req = 1'b1;
      lsb_addr = la; lsb_size = ls; lsb_signed = sg; lsb_we = 1'b0; lsb_req = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         next_cycle();
         #1;
         if (fetch_ready) begin
            chk("both_fdata", fetch_data, fexp);
            if (!got_l) begin first_lsb = 1'b0; lat1 = c; chk("both_lat1", 32'(c), 32'd6); end
            else chk("both_lat2", 32'(c), 32'(lat1 + 4 + 3));
            got_f = 1'b1; fetch_req = 1'b0;
         end
         if (lsb_ready) begin
            chk("both_ldata", lsb_rdata, lexp);
            if (!got_f) begin first_lsb = 1'b1; lat1 = c; chk("both_lat1", 32'(c), 32'(nl + 2)); end
            else chk("both_lat2", 32'(c), 32'(lat1 + nl + 3));
            got_l = 1'b1; lsb_req = 1'b0;
         end
         if (got_f && got_l) break;
      end
      chk("both_done", got_f & got_l, 1'b1);
      chk("both_order", first_lsb, exp_lsb_first);
   endtask

   initial begin
      bit saw;
      int kind, n;
      logic [31:0] a;
      logic [1:0]  sz;
      rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
      fetch_req = 1'b0; fetch_addr = '0;
      lsb_req = 1'b0; lsb_we = 1'b0; lsb_size = '0; lsb_signed = 1'b0;
      lsb_addr = '0; lsb_wdata = '0;
      preload(32'h100, 8'h13); preload(32'h101, 8'h05);
      preload(32'h102, 8'hA0); preload(32'h103, 8'h00);
      preload(32'h20, 8'h80);
      repeat (3) next_cycle();
      rst_in = 1'b0;
      #1;
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_dout", 32'(mem_dout), 32'h0);
      chk("rst_mem_wr", mem_wr, 1'b0);
      chk("rst_fready", fetch_ready, 1'b0);
      chk("rst_lready", lsb_ready, 1'b0);
      chk("rst_fdata", fetch_data, 32'h0);
      chk("rst_ldata", lsb_rdata, 32'h0);
      chk("rst_busy", busy, 1'b0);

      // simultaneous requests: LSB first after reset, fetch on the repeat
      run_both(32'h100, 32'h20, 2'd0, 1'b1);
      run_both(32'h100, 32'h20, 2'd0, 1'b1);

      do_read(1'b1, 32'h100, 2'd2, 1'b0, "fetch100");
      chk("fetch100_val", fetch_data, 32'h00A0_0513);
      do_read(1'b0, 32'h20, 2'd0, 1'b1, "lb_signed");
      chk("lb_signed_val", lsb_rdata, 32'hFFFF_FF80);
      do_read(1'b0, 32'h20, 2'd0, 1'b0, "lb_unsigned");
      chk("lb_unsigned_val", lsb_rdata, 32'h0000_0080);

      do_store(32'h0003_0000, 2'd0, 32'h41, 0, 0, 5, "io_store");

      // flush in IDLE blocks a fetch grant
      next_cycle();
      fetch_addr = 32'h200; fetch_req = 1'b1; flush = 1'b1;
      next_cycle();
      #1;
      chk("flush_idle_block", busy, 1'b0);
      flush = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         next_cycle();
         if (c == 2) begin #1; chk("flush_busy_read", busy, 1'b1); end
         if (c == 3) begin flush = 1'b1; fetch_req = 1'b0; end
      end
      next_cycle();
      flush = 1'b0;
      #1;
      chk("flush_idle", busy, 1'b0);
      saw = fetch_ready;
      repeat (6) begin
         next_cycle();
         #1;
         saw = saw | fetch_ready;
      end
      chk("flush_no_ready", saw, 1'b0);
      do_store(32'h40, 2'd2, 32'hDEAD_BEEF, 0, 0, 0, "st_dead");
      do_read(1'b0, 32'h40, 2'd2, 1'b0, "ld_dead");
      chk("ld_dead_val", lsb_rdata, 32'hDEAD_BEEF);

      do_store(32'h80, 2'd2, 32'h1122_3344, 2, 3, 0, "st_stall");

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 3);
         a    = 32'($urandom_range(0, 32'h0000_FFFF));
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFD + 32'($urandom_range(0, 2));
         sz   = 2'($urandom_range(0, 3));
         n    = nb(sz);
         case (kind)
            0: do_read(1'b1, a, 2'd2, 1'b0, "rnd_fetch");
            1: do_read(1'b0, a, sz, 1'($urandom_range(0, 1)), "rnd_load");
            2: do_store(a, sz, $urandom, $urandom_range(1, n), $urandom_range(0, 3), 0, "rnd_store");
            default: run_both(32'($urandom_range(0, 32'h0000_FFFF)), a, sz, 1'($urandom_range(0, 1)));
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
